// File: rtl/sigcapture.sv
// sigcapture: records an 8-bit sample stream into an internal RAM after a
// level-crossing or forced trigger. Samples can be decimated. The stored
// waveform is read back through a registered port with a latency of one clock.
module sigcapture #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [WIDTH-1:0]      din,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trig_force,
   input  logic [WIDTH-1:0]      level,
   input  logic [7:0]            decim,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   wr_count
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]            state_q,      state_d;
   logic [WIDTH-1:0]      prev_q,       prev_d;
   logic                  prev_valid_q, prev_valid_d;
   logic [7:0]            dcnt_q,       dcnt_d;
   logic [ADDR_WIDTH:0]   wr_count_q,   wr_count_d;
   logic                  busy_q,       busy_d;
   logic                  done_q,       done_d;
   logic [WIDTH-1:0]      rd_data_q;

   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [ADDR_WIDTH:0]   wr_count_inc;
   logic                  level_cross;

   logic [WIDTH-1:0]      mem [DEPTH];

   assign wr_count_inc = wr_count_q + 1'b1;
   assign level_cross  = prev_valid_q && (prev_q < level) && (din >= level);

   // Next-state, counters and write-port control.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch can be inferred.
      state_d      = state_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      dcnt_d       = dcnt_q;
      wr_count_d   = wr_count_q;
      we           = 1'b0;
      waddr        = '0;

      if (abort) begin
         // abort wins over arm, trigger and writes; counts and data are kept.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state_d      = S_ARMED;
                  wr_count_d   = '0;
                  prev_valid_d = 1'b0;
                  dcnt_d       = '0;
               end
            end
            S_ARMED: begin
               if (en) begin
                  prev_d       = din;
                  prev_valid_d = 1'b1;
                  if (trig_force || level_cross) begin
                     we         = 1'b1;
                     waddr      = '0;
                     wr_count_d = {{ADDR_WIDTH{1'b0}}, 1'b1};
                     dcnt_d     = decim;
                     state_d    = S_CAPTURE;
                  end
               end
            end
            S_CAPTURE: begin
               if (en) begin
                  if (dcnt_q == 8'd0) begin
                     we         = 1'b1;
                     waddr      = wr_count_q[ADDR_WIDTH-1:0];
                     wr_count_d = wr_count_inc;
                     dcnt_d     = decim;
                     if (wr_count_inc == FULL_CNT) begin
                        state_d = S_DONE;
                     end
                  end else begin
                     dcnt_d = dcnt_q - 8'd1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   // Control state and the registered read port, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         dcnt_q       <= '0;
         wr_count_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments make every flop see the pre-edge
         // values; this is also what gives the read port read-before-write.
         state_q      <= state_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         dcnt_q       <= dcnt_d;
         wr_count_q   <= wr_count_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         rd_data_q    <= mem[rd_addr];
      end
   end

   // Sample RAM write port.
   always_ff @(posedge clk) begin
      // NOTE: the RAM has no reset, so it maps onto block RAM; contents
      // from a capture survive reset.
      if (we) begin
         mem[waddr] <= din;
      end
   end

   assign rd_data  = rd_data_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_sigcapture.sv
// Self-checking bench for sigcapture: directed scenarios followed by random
// traffic, all compared against a behavioural model of the capture rules.
module tb_sigcapture;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [7:0] din = '0;
   logic       arm = 1'b0;
   logic       abort = 1'b0;
   logic       trig_force = 1'b0;
   logic [7:0] level = '0;
   logic [7:0] decim = '0;
   logic [7:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic [8:0] wr_count;

   sigcapture #(.WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .arm(arm), .abort(abort),
      .trig_force(trig_force), .level(level), .decim(decim),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_ARMED, M_CAPTURE, M_DONE} mode_e;

   mode_e m_mode;
   int    m_cnt;         // samples stored
   int    m_prev;        // last valid sample while armed, -1 = none yet
   int    m_seen;        // valid samples skipped since the last store
   int    m_gap;         // samples to skip before the next store
   int    m_mem [256];   // -1 = contents unknown
   int    m_rd;          // expected rd_data, -1 = unknown

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_cnt  = 0;
      m_prev = -1;
      m_seen = 0;
      m_gap  = 0;
      m_rd   = 0;
   endtask

   task automatic store(input int v);
      m_mem[m_cnt] = v;
      m_cnt++;
      m_seen = 0;
      m_gap  = int'(decim);
   endtask

   // Effect of one rising edge with the inputs currently applied.
   task automatic model_edge();
      if (!rst) begin
         model_reset();
         return;
      end
      m_rd = m_mem[rd_addr];
      if (abort) begin
         m_mode = M_IDLE;
      end else if ((m_mode == M_IDLE || m_mode == M_DONE) && arm) begin
         m_mode = M_ARMED;
         m_cnt  = 0;
         m_prev = -1;
      end else if (m_mode == M_ARMED && en) begin
         if (trig_force || (m_prev >= 0 && m_prev < int'(level) && int'(din) >= int'(level))) begin
            m_cnt = 0;
            store(int'(din));
            m_mode = M_CAPTURE;
         end
         m_prev = int'(din);
      end else if (m_mode == M_CAPTURE && en) begin
         if (m_seen == m_gap) begin
            store(int'(din));
            if (m_cnt == 256) m_mode = M_DONE;
         end else begin
            m_seen++;
         end
      end
   endtask

   task automatic compare_all();
      check("busy", busy, (m_mode == M_ARMED || m_mode == M_CAPTURE));
      check("done", done, (m_mode == M_DONE));
      check("wr_count", wr_count, m_cnt);
      if (m_rd >= 0) check("rd_data", rd_data, m_rd);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      en = 1'b0; arm = 1'b0; abort = 1'b0; trig_force = 1'b0;
   endtask

   task automatic do_arm();
      idle_inputs();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask

   task automatic do_abort();
      idle_inputs();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [7:0] addr, input int exp);
      idle_inputs();
      rd_addr = addr;
      step();
      check(tag, rd_data, exp);
   endtask

   initial begin
      int v;
      int guard;
      int old;
      logic [7:0] wa;

      for (int i = 0; i < 256; i++) m_mem[i] = -1;
      model_reset();

      // --- reset, then idle traffic without arm ---
      #1;
      compare_all();
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         en = 1'b1; din = 8'($urandom); trig_force = 1'b1; level = 8'd10;
         step();
      end
      check("idle_busy", busy, 0);
      check("idle_count", wr_count, 0);

      // --- level trigger on a ramp, fill the whole buffer ---
      level = 8'd128; decim = 8'd0;
      do_arm();
      foreach (din[i]) ;
      en = 1'b1;
      din = 8'd100; step();
      din = 8'd120; step();
      din = 8'd127; step();
      check("ramp_armed", busy, 1);
      check("ramp_no_store", wr_count, 0);
      v = 128; guard = 0;
      while (!done && guard < 300) begin
         din = 8'(v); v++; guard++;
         step();
      end
      check("ramp_timeout", (guard < 300), 1);
      check("ramp_done", done, 1);
      check("ramp_count", wr_count, 256);
      read_check("ramp_mem0", 8'd0, 128);
      read_check("ramp_mem5", 8'd5, 133);

      // --- first valid sample after arming cannot level-trigger ---
      do_arm();
      en = 1'b1;
      din = 8'd200; step();
      check("first_no_trig", wr_count, 0);
      din = 8'd50;  step();
      din = 8'd130; step();
      check("second_trig", wr_count, 1);
      v = 131;
      while (m_cnt < 10) begin
         din = 8'(v); v++;
         step();
      end
      // abort mid-capture keeps the count and data
      do_abort();
      check("abort_busy", busy, 0);
      check("abort_count", wr_count, 10);
      read_check("abort_mem0", 8'd0, 130);
      read_check("abort_mem9", 8'd9, 139);
      read_check("abort_mem10", 8'd10, 138);  // untouched since the ramp
      // abort and arm together stay idle
      idle_inputs(); abort = 1'b1; arm = 1'b1;
      step();
      check("abort_arm_busy", busy, 0);

      // --- decimation 3 with en every other cycle, forced trigger ---
      decim = 8'd3;
      do_arm();
      trig_force = 1'b1; en = 1'b0; din = 8'd0;
      step();
      check("force_waits_en", wr_count, 0);
      v = 0;
      for (int c = 0; c < 40; c++) begin
         en = (c % 2 == 0);
         din = 8'(v);
         trig_force = (v == 0);
         arm = (c == 9);               // arm during capture is ignored
         step();
         if (en) v++;
      end
      arm = 1'b0;
      check("decim_count", wr_count, 5);
      do_abort();
      read_check("decim_mem0", 8'd0, 0);
      read_check("decim_mem1", 8'd1, 4);
      read_check("decim_mem2", 8'd2, 8);
      read_check("decim_mem3", 8'd3, 12);

      // --- read-before-write at the live write address, then async reset ---
      decim = 8'd0;
      do_arm();
      en = 1'b1; trig_force = 1'b1; din = 8'd77; rd_addr = 8'd0;
      step();
      trig_force = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wa = 8'(m_cnt);
         old = m_mem[wa];
         rd_addr = wa;
         din = 8'(200 + i);
         step();
         check("rbw_old", rd_data, old);
      end
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("async_busy", busy, 0);
      check("async_count", wr_count, 0);
      check("async_rd", rd_data, 0);
      step();
      #2 rst = 1'b1;
      read_check("kept_after_rst", 8'd2, 201);

      // --- random traffic ---
      for (int c = 0; c < 3000; c++) begin
         en         = ($urandom_range(0, 9) < 7);
         din        = 8'($urandom);
         arm        = ($urandom_range(0, 39) == 0);
         abort      = ($urandom_range(0, 149) == 0);
         trig_force = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 63) == 0) level = 8'($urandom);
         decim      = 8'($urandom_range(0, 3));
         rd_addr    = 8'($urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
